// File: rtl/riscv_bus_pkg.sv
// Shared definitions for native-bus masters: BIST state encoding,
// write-strobe constants and the word-address helper.
package riscv_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_GAP = 3'd2,
    RD_REQ = 3'd3,
    RD_GAP = 3'd4,
    FIN    = 3'd5
  } bist_state_e;

  localparam logic [3:0] WSTRB_WORD = 4'hF;
  localparam logic [3:0] WSTRB_READ = 4'h0;

  // Byte address of a 32-bit word; the sum wraps naturally at 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] index);
    return base + (index << 2);
  endfunction

endpackage

// File: rtl/native_bus_txn.sv
// Holds one native-bus request and its completion timer. A request is
// loaded by issue_i and retired either by mem_ready (which always wins)
// or by the timer reaching TIMEOUT cycles without a response.
module native_bus_txn #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        mem_ready_i,
  output logic        valid_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        ready_pulse_o,
  output logic        timeout_pulse_o
);

  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int TW   = (TLIM > 0) ? $clog2(TLIM + 1) : 1;

  logic          valid_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [TW-1:0] timer_q;
  logic          expire;

  assign expire          = (timer_q == TW'(TLIM));
  assign ready_pulse_o   = valid_q & mem_ready_i;
  assign timeout_pulse_o = valid_q & ~mem_ready_i & expire;

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign wstrb_o = wstrb_q;

  // Load a new request, then count waiting cycles until ready or expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      timer_q <= '0;
    end else if (issue_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      wstrb_q <= wstrb_i;
      timer_q <= '0;
    end else if (valid_q && (mem_ready_i || expire)) begin
      valid_q <= 1'b0;
      timer_q <= '0;
    end else if (valid_q) begin
      timer_q <= timer_q + TW'(1);
    end
  end

endmodule

// File: rtl/mem_bist_master.sv
// Memory BIST master: writes addr^SEED to WORDS consecutive words, reads
// them back and reports the first mismatch or a bus timeout.
module mem_bist_master
  import riscv_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          WORDS     = 256,
  parameter logic [31:0] SEED      = 32'hA5A5_5A5A,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] fail_addr,
  output logic [31:0] fail_data,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  bist_state_e      state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      fail_addr_q, fail_addr_d;
  logic [31:0]      fail_data_q, fail_data_d;

  logic             issue;
  logic [31:0]      issue_addr;
  logic [31:0]      issue_wdata;
  logic [3:0]       issue_wstrb;
  logic             ready_pulse;
  logic             timeout_pulse;
  logic [IDX_W-1:0] next_idx;
  logic [31:0]      next_addr;

  assign next_idx  = index_q + IDX_W'(1);
  assign next_addr = word_addr(BASE_ADDR, 32'(next_idx));

  native_bus_txn #(
    .TIMEOUT(TIMEOUT)
  ) u_txn (
    .clk            (clk),
    .rst_n          (rst),
    .issue_i        (issue),
    .addr_i         (issue_addr),
    .wdata_i        (issue_wdata),
    .wstrb_i        (issue_wstrb),
    .mem_ready_i    (mem_ready),
    .valid_o        (mem_valid),
    .addr_o         (mem_addr),
    .wdata_o        (mem_wdata),
    .wstrb_o        (mem_wstrb),
    .ready_pulse_o  (ready_pulse),
    .timeout_pulse_o(timeout_pulse)
  );

  // Sequence the write pass, the read pass and the result capture.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    issue       = 1'b0;
    issue_addr  = BASE_ADDR;
    issue_wdata = '0;
    issue_wstrb = WSTRB_READ;
    unique case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d     = WR_REQ;
          index_d     = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          issue       = 1'b1;
          issue_addr  = BASE_ADDR;
          issue_wdata = BASE_ADDR ^ SEED;
          issue_wstrb = WSTRB_WORD;
        end
      end
      WR_REQ: begin
        if (ready_pulse) begin
          state_d = WR_GAP;
        end else if (timeout_pulse) begin
          state_d     = FIN;
          timeout_d   = 1'b1;
          pass_d      = 1'b0;
          fail_addr_d = mem_addr;
          fail_data_d = '0;
        end
      end
      WR_GAP: begin
        issue = 1'b1;
        if (index_q == LAST_IDX) begin
          state_d    = RD_REQ;
          index_d    = '0;
          issue_addr = BASE_ADDR;
        end else begin
          state_d     = WR_REQ;
          index_d     = next_idx;
          issue_addr  = next_addr;
          issue_wdata = next_addr ^ SEED;
          issue_wstrb = WSTRB_WORD;
        end
      end
      RD_REQ: begin
        if (ready_pulse) begin
          if (mem_rdata == (mem_addr ^ SEED)) begin
            state_d = RD_GAP;
          end else begin
            state_d     = FIN;
            pass_d      = 1'b0;
            fail_addr_d = mem_addr;
            fail_data_d = mem_rdata;
          end
        end else if (timeout_pulse) begin
          state_d     = FIN;
          timeout_d   = 1'b1;
          pass_d      = 1'b0;
          fail_addr_d = mem_addr;
          fail_data_d = '0;
        end
      end
      RD_GAP: begin
        if (index_q == LAST_IDX) begin
          state_d = FIN;
          pass_d  = 1'b1;
        end else begin
          state_d    = RD_REQ;
          index_d    = next_idx;
          issue      = 1'b1;
          issue_addr = next_addr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, word index and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      index_q     <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign busy      = (state_q == WR_REQ) || (state_q == WR_GAP) ||
                     (state_q == RD_REQ) || (state_q == RD_GAP);
  assign done      = (state_q == FIN);
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign mem_instr = 1'b0;

endmodule

// File: tb/tb_mem_bist_master.sv
// Scoreboard bench for mem_bist_master (WORDS=4, BASE_ADDR=0, TIMEOUT=10).
// Tests queue expected bus requests and results; a monitor pops and compares
// them as the DUT raises mem_valid or done.
module tb_mem_bist_master;

  localparam logic [31:0] SEED = 32'hA5A5_5A5A;
  localparam int MODE_ONE     = 0;
  localparam int MODE_CORRUPT = 1;
  localparam int MODE_NONE    = 2;
  localparam int MODE_RAND    = 3;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  typedef struct {
    logic        pass;
    logic        tout;
    logic [31:0] faddr;
    logic [31:0] fdata;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout;
  logic [31:0] fail_addr, fail_data;
  logic        mem_valid, mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = MODE_ONE;
  int delay = 1;
  int waitCnt = 0;
  logic [31:0] mem [4];

  txn_t expQ[$];
  res_t resQ[$];
  int   riseCycles[$];
  int   lastRise = 0;
  int   lastFall = 0;
  int   doneCyc = 0;
  logic prevValid = 1'b0;
  logic prevDone = 1'b0;
  txn_t held;
  txn_t expT;
  res_t expR;

  logic [31:0] WDATA_EXP [4];

  mem_bist_master #(
    .BASE_ADDR(32'h0000_0000),
    .WORDS    (4),
    .SEED     (SEED),
    .TIMEOUT  (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter for latency measurements.
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expectWrites(input int n);
    for (int i = 0; i < n; i++) begin
      expQ.push_back('{addr: 32'(4 * i), wdata: WDATA_EXP[i], wstrb: 4'hF});
    end
  endtask

  task automatic expectReads(input int n);
    for (int i = 0; i < n; i++) begin
      expQ.push_back('{addr: 32'(4 * i), wdata: 32'h0, wstrb: 4'h0});
    end
  endtask

  task automatic expectResult(input logic p, input logic t, input logic [31:0] fa, input logic [31:0] fd);
    resQ.push_back('{pass: p, tout: t, faddr: fa, fdata: fd});
  endtask

  task automatic waitDone(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(done), 32'h1);
    @(negedge clk);
    checkOutput({name, "_expq_empty"}, 32'(expQ.size()), 32'h0);
    checkOutput({name, "_resq_empty"}, 32'(resQ.size()), 32'h0);
  endtask

  // Responder: ready after a configurable delay, backed by a 4-word memory.
  always @(negedge clk) begin
    if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (mem_valid && mode != MODE_NONE) begin
      if (waitCnt >= delay) begin
        mem_ready = 1'b1;
        if (mem_wstrb == 4'hF) begin
          mem[mem_addr[3:2]] = mem_wdata;
          mem_rdata = 32'h0;
        end else if (mode == MODE_CORRUPT && mem_addr == 32'h8) begin
          mem_rdata = 32'h0;
        end else begin
          mem_rdata = mem[mem_addr[3:2]];
        end
        waitCnt = 0;
        delay = (mode == MODE_RAND) ? int'($urandom_range(7, 0)) : 1;
      end else begin
        waitCnt++;
      end
    end else begin
      waitCnt = 0;
    end
  end

  // Monitor: pops expected requests/results as the DUT presents them.
  always @(negedge clk) begin
    if (mem_valid && !prevValid) begin
      riseCycles.push_back(cyc);
      lastRise = cyc;
      held = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_req: got addr %h wstrb %h expected no request", mem_addr, mem_wstrb);
      end else begin
        expT = expQ.pop_front();
        checkOutput("req_addr", mem_addr, expT.addr);
        checkOutput("req_wdata", mem_wdata, expT.wdata);
        checkOutput("req_wstrb", 32'(mem_wstrb), 32'(expT.wstrb));
      end
    end else if (mem_valid && prevValid) begin
      checkOutput("stable_addr", mem_addr, held.addr);
      checkOutput("stable_wdata", mem_wdata, held.wdata);
      checkOutput("stable_wstrb", 32'(mem_wstrb), 32'(held.wstrb));
    end
    if (!mem_valid && prevValid) lastFall = cyc;
    if (done && !prevDone) begin
      doneCyc = cyc;
      if (resQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        expR = resQ.pop_front();
        checkOutput("res_pass", 32'(pass), 32'(expR.pass));
        checkOutput("res_timeout", 32'(timeout), 32'(expR.tout));
        checkOutput("res_fail_addr", fail_addr, expR.faddr);
        checkOutput("res_fail_data", fail_data, expR.fdata);
      end
    end
    prevValid = mem_valid;
    prevDone = done;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    WDATA_EXP[0] = 32'hA5A5_5A5A;
    WDATA_EXP[1] = 32'hA5A5_5A5E;
    WDATA_EXP[2] = 32'hA5A5_5A52;
    WDATA_EXP[3] = 32'hA5A5_5A56;

    // Reset state
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_pass", 32'(pass), 32'h0);
    checkOutput("rst_timeout", 32'(timeout), 32'h0);
    checkOutput("rst_fail_addr", fail_addr, 32'h0);
    checkOutput("rst_fail_data", fail_data, 32'h0);
    checkOutput("rst_valid", 32'(mem_valid), 32'h0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    checkOutput("rst_wstrb", 32'(mem_wstrb), 32'h0);
    checkOutput("mem_instr", 32'(mem_instr), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1-cycle responder, full pass, 3 cycles per transfer
    $display("[TB] test: one-cycle responder");
    mode = MODE_ONE;
    riseCycles.delete();
    expectWrites(4);
    expectReads(4);
    expectResult(1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus();
    checkOutput("busy_running", 32'(busy), 32'h1);
    waitDone("pass_run", 100);
    checkOutput("rise_count", 32'(riseCycles.size()), 32'd8);
    if (riseCycles.size() == 8) begin
      for (int i = 0; i < 7; i++) begin
        checkOutput("xfer_spacing", 32'(riseCycles[i+1] - riseCycles[i]), 32'd3);
      end
      checkOutput("done_latency", 32'(doneCyc - riseCycles[7]), 32'd3);
    end
    checkOutput("busy_fin", 32'(busy), 32'h0);

    // Read mismatch at 0x8
    $display("[TB] test: mismatch at 0x8");
    mode = MODE_CORRUPT;
    expectWrites(4);
    expectReads(3);
    expectResult(1'b0, 1'b0, 32'h8, 32'h0);
    applyStimulus();
    waitDone("mismatch_run", 100);
    repeat (5) @(negedge clk);

    // Responder never ready
    $display("[TB] test: timeout");
    mode = MODE_NONE;
    expectWrites(1);
    expectResult(1'b0, 1'b1, 32'h0, 32'h0);
    applyStimulus();
    waitDone("timeout_run", 100);
    checkOutput("timeout_width", 32'(lastFall - lastRise), 32'd10);

    // Reset during the third write
    $display("[TB] test: reset mid-run");
    mode = MODE_ONE;
    riseCycles.delete();
    expectWrites(3);
    applyStimulus();
    n = 0;
    while (!(mem_valid === 1'b1 && mem_addr === 32'h8) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("third_write_seen", 32'(n < 50), 32'h1);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(mem_valid), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("post_rst_rises", 32'(riseCycles.size()), 32'd3);
    checkOutput("post_rst_busy", 32'(busy), 32'h0);
    expectWrites(4);
    expectReads(4);
    expectResult(1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus();
    waitDone("rerun_after_rst", 100);

    // Random delays, start ignored while busy, restart from FIN
    $display("[TB] test: random delays");
    mode = MODE_RAND;
    expectWrites(4);
    expectReads(4);
    expectResult(1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus();
    repeat (5) @(negedge clk);
    applyStimulus();
    waitDone("random_run", 300);
    checkOutput("fin_done_held", 32'(done), 32'h1);
    expectWrites(4);
    expectReads(4);
    expectResult(1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus();
    checkOutput("restart_done_clr", 32'(done), 32'h0);
    checkOutput("restart_pass_clr", 32'(pass), 32'h0);
    waitDone("random_rerun", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bist_master.md
MEM_BIST_MASTER -- requirements
Module: mem_bist_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word tested (word-aligned).
REQ-002 SHALL have parameter WORDS, default 256, number of 32-bit words tested (1..1024).
REQ-003 SHALL have parameter SEED, default 32'hA5A5_5A5A, pattern XOR key.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles waited for mem_ready per transfer.
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1  one-cycle request to run the test.
REQ-008 SHALL have port busy  out  1  test in progress.
REQ-009 SHALL have port done  out  1  test finished; held until the next start.
REQ-010 SHALL have port pass  out  1  valid when done=1; 1 = all words matched, no timeout.
REQ-011 SHALL have port timeout  out  1  valid when done=1; run aborted by timeout.
REQ-012 SHALL have port fail_addr  out  32  byte address of the first mismatch.
REQ-013 SHALL have port fail_data  out  32  data read at fail_addr.
REQ-014 SHALL have port mem_valid  out  1  native-bus request valid.
REQ-015 SHALL have port mem_instr  out  1  constant 0.
REQ-016 SHALL have port mem_ready  in  1  responder completion strobe.
REQ-017 SHALL have port mem_addr  out  32  byte address.
REQ-018 SHALL have port mem_wdata  out  32  write data.
REQ-019 SHALL have port mem_wstrb  out  4  4'hF = write, 4'h0 = read.
REQ-020 SHALL have port mem_rdata  in  32  read data, sampled only on the mem_ready edge.

Function
REQ-021 SHALL implement states IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FIN.
- IDLE -> WR_REQ on start.
- WR_REQ -> WR_GAP on mem_ready.
- WR_GAP -> WR_REQ for the next word, or RD_REQ at index 0 after the last word.
- RD_REQ -> RD_GAP on mem_ready with a match.
- RD_GAP -> RD_REQ, or FIN after the last word.
- Any REQ state -> FIN on mismatch or timeout.
- FIN -> WR_REQ on start.
REQ-022 SHALL drive mem_valid=1 only in WR_REQ/RD_REQ, asserted the cycle after start is sampled.
- mem_addr, mem_wdata and mem_wstrb SHALL be registered and held stable while mem_valid=1.
REQ-023 SHALL deassert mem_valid on the edge at which mem_ready=1 is sampled.
- mem_valid SHALL stay low for exactly one cycle (the GAP state) between transfers.
- With a responder that strobes mem_ready one cycle after valid, each transfer SHALL therefore take 3 cycles.
REQ-024 SHALL drive mem_addr = BASE_ADDR + 4*index, index 0..WORDS-1, using 32-bit wrap-around arithmetic.
REQ-025 SHALL write mem_wdata = mem_addr ^ SEED with mem_wstrb=4'hF in the write phase, and issue reads with mem_wstrb=4'h0 and mem_wdata=0.
REQ-026 SHALL compare mem_rdata against mem_addr ^ SEED on the read mem_ready edge.
- On the first mismatch: latch fail_addr=mem_addr and fail_data=mem_rdata, set pass=0, go to FIN.
REQ-027 SHALL count cycles in each REQ state; when the count reaches TIMEOUT with no mem_ready:
- set timeout=1, pass=0, mem_valid=0, go to FIN.
- fail_addr SHALL equal the stalled address and fail_data SHALL be 0.
REQ-028 SHALL assert busy in every state except IDLE and FIN, and assert done only in FIN.
REQ-029 SHALL ignore start while busy=1.
- start in FIN SHALL clear done, pass, timeout, fail_addr and fail_data and restart at index 0.
REQ-030 SHALL give mem_ready priority over timeout when both occur on the same edge.
REQ-031 SHALL ignore mem_ready while mem_valid=0.

Reset
REQ-032 SHALL, while rst=0, asynchronously force:
- state=IDLE, index=0, timer=0;
- mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0;
- busy=0, done=0, pass=0, timeout=0, fail_addr=0, fail_data=0.
REQ-033 SHALL abandon an in-flight transfer on reset mid-operation and issue nothing until a new start after reset release.

Structure
REQ-034 SHALL take the state encoding, WSTRB_WORD=4'hF and WSTRB_READ=4'h0 from the shared package riscv_bus_pkg.
REQ-035 SHALL instantiate a single sub-module, native_bus_txn, which holds one request (valid, addr, wdata, wstrb), its timeout counter, and the ready/timeout completion pulses.

Verification
REQ-036 SHALL cover: 1-cycle responder, WORDS=4, BASE_ADDR=0, start pulse.
- Expect writes of 0xA5A55A5A, 0xA5A55A5E, 0xA5A55A52, 0xA5A55A56 to 0x0, 0x4, 0x8, 0xC.
- Expect 4 reads, then done=1, pass=1, 3 cycles per transfer.
REQ-037 SHALL cover: responder returns 0 for address 0x8 -> done=1, pass=0, fail_addr=0x8, fail_data=0, no read issued at 0xC.
REQ-038 SHALL cover: responder never readies, TIMEOUT=10 -> mem_valid falls 10 cycles after rising, timeout=1, fail_addr=BASE_ADDR, done=1.
REQ-039 SHALL cover: rst=0 during the third write -> mem_valid=0 and busy=0 immediately; after release, with no start, no requests are issued.
- A subsequent start reruns from 0x0.
REQ-040 SHALL cover: start while busy is ignored; random ready delay 0-7 cycles with signals checked stable while valid -> pass=1; second start in FIN clears done and reruns.
